pipe_adder: RTL and testbench

Parametrised, valid/ready-pipelined two-stage adder/subtractor: the registered successor to the team's combinational interface-driven adder. Operand pairs are accepted through an upstream handshake, computed in a two-stage pipeline with full back-pressure, and presented on a downstream handshake with carry, signed-overflow and a result counter. It sits between a stimulus or producer interface and any consumer that may stall. Optional signed saturation is selected at compile time.

---
 rtl/pipe_adder.sv | 149 ++++++++++++++
 tb/tb_pipe_adder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_adder
//  Description : Two-stage valid/ready pipelined adder/subtractor with carry,
//                signed overflow, sticky overflow flag and result counter.
//                Compile-time option PIPE_ADDER_SAT_EN enables signed
//                saturation of the result when overflow occurs.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] res_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef PIPE_ADDER_SAT_EN
    // Most positive and most negative two's-complement values.
    localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Stage 1 holding registers: operand A, pre-conditioned operand B, op.
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_op;

    // Stage 2 result registers; these drive the output port directly.
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_cout;
    logic             r_ovf;

    // Status registers.
    logic             r_ovf_sticky;
    logic [CNT_W-1:0] r_res_cnt;

    // Handshake and datapath nets.
    logic             w_s2_ready;
    logic             w_in_fire;
    logic             w_s1_adv;
    logic             w_out_fire;
    logic [WIDTH:0]   w_sum_ext;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_y_next;

    // Back-pressure chain: a stage can take new data when it is empty or
    // when its content leaves in the same cycle.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    // Single adder serves both operations: subtraction is a + ~b + 1, with
    // the inversion already applied when the operand was captured.
    assign w_sum_ext = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {{WIDTH{1'b0}}, r_s1_op};
    assign w_sum     = w_sum_ext[WIDTH-1:0];

    // Signed overflow: operands of equal sign yielding a result of the other sign.
    assign w_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);

    // Result selection; saturation direction follows the sign of operand A.
    always_comb begin
        w_y_next = w_sum;
`ifdef PIPE_ADDER_SAT_EN
        if (w_ovf) begin
            w_y_next = r_s1_a[WIDTH-1] ? c_sat_neg : c_sat_pos;
        end
`endif
    end

    // Stage 1: capture operands on an input transfer, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_fire) begin
                r_s1_a  <= a;
                r_s1_b  <= op ? ~b : b;
                r_s1_op <= op;
            end
        end
    end

    // Stage 2: register the computed result when stage 1 advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv) begin
                r_y    <= w_y_next;
                r_cout <= w_sum_ext[WIDTH];
                r_ovf  <= w_ovf;
            end
        end
    end

    // Status: count delivered results and remember any delivered overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_cnt    <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (w_out_fire) begin
            r_res_cnt <= r_res_cnt + c_cnt_one;
            if (r_ovf) begin
                r_ovf_sticky <= 1'b1;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign y          = r_y;
    assign cout       = r_cout;
    assign ovf        = r_ovf;
    assign ovf_sticky = r_ovf_sticky;
    assign res_cnt    = r_res_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_adder
//  Description : Self-checking bench for pipe_adder (WIDTH=8, CNT_W=4).
//                Honors PIPE_ADDER_SAT_EN when the design is built with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          cout;
    logic          ovf;
    logic          ovf_sticky;
    logic [CW-1:0] res_cnt;

    int errors = 0;
    int checks = 0;

    pipe_adder #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .cout       (cout),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .res_cnt    (res_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic         cout;
        logic         ovf;
        int           stamp;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] obs[$];
    int           edge_cnt = 0;
    int           m_cnt    = 0;
    bit           m_sticky = 1'b0;
    bit           p_in     = 1'b0;
    bit           p_out    = 1'b0;
    exp_t         p_new;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Arithmetic meaning of one operation on W-bit operands.
    function automatic exp_t calc(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop);
        exp_t   e;
        longint lim, ua, ub, sa, sb, ures, sres;
        lim  = longint'(1) << (W - 1);
        ua   = longint'(ia);
        ub   = longint'(ib);
        sa   = (ua >= lim) ? ua - 2 * lim : ua;
        sb   = (ub >= lim) ? ub - 2 * lim : ub;
        if (iop) begin
            ures   = ua - ub;
            sres   = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ures   = ua + ub;
            sres   = sa + sb;
            e.cout = (ures >= 2 * lim);
        end
        e.ovf = (sres >= lim) || (sres < -lim);
        e.y   = ures[W-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (e.ovf) begin
            e.y = (sres > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
        end
`endif
        e.stamp = 0;
        return e;
    endfunction

    // Reference pipeline: in-flight results ordered oldest first; the oldest
    // one is presented once at least one edge has passed since its capture.
    always @(negedge clk) begin
        edge_cnt++;
        if (rst) begin
            q.delete();
            m_cnt    = 0;
            m_sticky = 1'b0;
            p_in     = 1'b0;
            p_out    = 1'b0;
        end else begin
            if (p_out && q.size() > 0) begin
                obs.push_back(q[0].y);
                m_cnt = (m_cnt + 1) % (1 << CW);
                if (q[0].ovf) m_sticky = 1'b1;
                void'(q.pop_front());
            end
            if (p_in) begin
                p_new.stamp = edge_cnt;
                q.push_back(p_new);
            end
            chk("out_valid", out_valid, (q.size() > 0 && edge_cnt - q[0].stamp >= 1));
            chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            chk("res_cnt", res_cnt, m_cnt);
            chk("ovf_sticky", ovf_sticky, m_sticky);
            if (q.size() > 0 && edge_cnt - q[0].stamp >= 1) begin
                chk("y", y, q[0].y);
                chk("cout", cout, q[0].cout);
                chk("ovf", ovf, q[0].ovf);
            end
            p_out = out_valid && out_ready;
            p_in  = in_valid && in_ready;
            p_new = calc(a, b, op);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one operand pair until it is accepted; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop);
        int n = 0;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        op       = iop;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout_fail("send");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        op       = 1'($urandom);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] ey, input logic ec, input logic eo);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout_fail({name, "_wait"});
        chk({name, "_y"}, y, ey);
        chk({name, "_cout"}, cout, ec);
        chk({name, "_ovf"}, ovf, eo);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || out_valid) timeout_fail("drain");
        tick();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return 8'h7F;
            1:       return 8'h80;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state while idle.
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res_cnt", res_cnt, 0);
        chk("rst_sticky", ovf_sticky, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_y", y, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        tick();

        // Back-to-back add with carry and subtract going negative.
        out_ready = 1'b1;
        send(8'hFF, 8'h01, 1'b0);
        send(8'h05, 8'h07, 1'b1);
        expect_out("add_wrap", 8'h00, 1'b1, 1'b0);
        expect_out("sub_neg", 8'hFE, 1'b0, 1'b0);
        @(negedge clk);
        chk("cnt_two", res_cnt, 2);
        tick();

        // Signed overflow on add and on subtract.
        send(8'd100, 8'd100, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
        expect_out("ovf_add", 8'h7F, 1'b0, 1'b1);
`else
        expect_out("ovf_add", 8'hC8, 1'b0, 1'b1);
`endif
        tick();
        send(8'h80, 8'h01, 1'b1);
`ifdef PIPE_ADDER_SAT_EN
        expect_out("ovf_sub", 8'h80, 1'b1, 1'b1);
`else
        expect_out("ovf_sub", 8'h7F, 1'b1, 1'b1);
`endif
        @(negedge clk);
        chk("sticky_set", ovf_sticky, 1);
        tick();

        // Back-pressure: fill both stages, hold, then release.
        out_ready = 1'b0;
        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd2, 1'b0);
        in_valid = 1'b1;
        a        = 8'd3;
        b        = 8'd3;
        op       = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_y_hold", y, 8'd2);
        end
        tick();
        out_ready = 1'b1;
        n0        = obs.size();
        send(8'd3, 8'd3, 1'b0);
        send(8'd4, 8'd4, 1'b0);
        drain();
        chk("bp_count", obs.size() - n0, 4);
        if (obs.size() - n0 == 4) begin
            chk("bp_res0", obs[n0],     8'd2);
            chk("bp_res1", obs[n0 + 1], 8'd4);
            chk("bp_res2", obs[n0 + 2], 8'd6);
            chk("bp_res3", obs[n0 + 3], 8'd8);
        end

        // Reset with both stages full.
        out_ready = 1'b0;
        send(8'd9, 8'd9, 1'b0);
        send(8'd10, 8'd10, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_res_cnt", res_cnt, 0);
        chk("arst_sticky", ovf_sticky, 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        send(8'd3, 8'd4, 1'b0);
        expect_out("post_rst", 8'd7, 1'b0, 1'b0);
        tick();

        // Counter wrap: 17 results on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(pick(), pick(), 1'($urandom));
        end
        drain();
        @(negedge clk);
        chk("cnt_wrap", res_cnt, 1);
        tick();

        // Random traffic with random stalls.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            op        = 1'($urandom);
            out_ready = ((i % 200) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
